// File: rtl/wb_cal_sequencer.sv
// Sequences white-balance calibration: CAL mode, settle N frames, strobe, read R/G/B, write back, MANUAL.
// Latency 1+N frames+1+1+3*(1+READ_LAT)+3+1 cycles; no backpressure, abort_i returns to IDLE next cycle.
module wb_cal_sequencer #(
  parameter int COEF_WIDTH      = 20,
  parameter int FRAME_CNT_WIDTH = 8,
  parameter int READ_LAT        = 2,
  parameter int TIMEOUT_CYCLES  = 2**24
) (
  input  logic                       clk_i,
  input  logic                       rstn_i,
  input  logic                       start_i,
  input  logic                       abort_i,
  input  logic [FRAME_CNT_WIDTH-1:0] settle_frames_i,
  input  logic                       sof_i,
  input  logic [COEF_WIDTH-1:0]      cur_coef_i,
  output logic [1:0]                 mode_o,
  output logic                       cal_stb_o,
  output logic [1:0]                 man_sel_o,
  output logic                       man_lock_o,
  output logic [COEF_WIDTH-1:0]      man_coef_o,
  output logic [COEF_WIDTH-1:0]      r_coef_o,
  output logic [COEF_WIDTH-1:0]      g_coef_o,
  output logic [COEF_WIDTH-1:0]      b_coef_o,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       err_o
);

  localparam int WD_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam int RL_W = (READ_LAT < 2) ? 1 : $clog2(READ_LAT);
  localparam logic [COEF_WIDTH-1:0] COEF_ONE = COEF_WIDTH'(1) << (COEF_WIDTH / 2);

  localparam logic [1:0] MODE_AUTO_GW = 2'd0;
  localparam logic [1:0] MODE_MANUAL  = 2'd2;
  localparam logic [1:0] MODE_CAL     = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE, S_SETTLE, S_STROBE, S_LATCH, S_RD_SEL, S_RD_WAIT, S_WR, S_SWITCH
  } state_t;

  state_t                     state_q, state_d;
  logic [FRAME_CNT_WIDTH-1:0] frame_cnt_q, frame_cnt_d;
  logic [WD_W-1:0]            wd_q, wd_d;
  logic [RL_W-1:0]            wait_q, wait_d;
  logic [1:0]                 idx_q, idx_d;
  logic [1:0]                 mode_q, mode_d;
  logic                       cal_stb_q, cal_stb_d;
  logic [1:0]                 man_sel_q, man_sel_d;
  logic                       man_lock_q, man_lock_d;
  logic [COEF_WIDTH-1:0]      man_coef_q, man_coef_d;
  logic [COEF_WIDTH-1:0]      r_q, r_d, g_q, g_d, b_q, b_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;
  logic                       err_q, err_d;
  logic [1:0]                 idx_nxt;

  assign idx_nxt = idx_q + 2'd1;

  always_comb begin
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    wd_d        = wd_q;
    wait_d      = wait_q;
    idx_d       = idx_q;
    mode_d      = mode_q;
    cal_stb_d   = 1'b0;
    man_sel_d   = man_sel_q;
    man_lock_d  = 1'b0;
    man_coef_d  = man_coef_q;
    r_d         = r_q;
    g_d         = g_q;
    b_d         = b_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_d       = err_q;

    case (state_q)
      S_IDLE: begin
        // sof_i is deliberately not looked at here, so a frame start coincident with start is not counted
        if (start_i) begin
          frame_cnt_d = settle_frames_i;
          wd_d        = '0;
          err_d       = 1'b0;
          mode_d      = MODE_CAL;
          busy_d      = 1'b1;
          state_d     = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (frame_cnt_q == '0) begin
          cal_stb_d = 1'b1;
          state_d   = S_STROBE;
        end else if (sof_i) begin
          frame_cnt_d = frame_cnt_q - FRAME_CNT_WIDTH'(1);
          wd_d        = '0;
        end else if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
          err_d   = 1'b1;
          mode_d  = MODE_AUTO_GW;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      S_STROBE: state_d = S_LATCH;
      S_LATCH: begin
        idx_d     = 2'd0;
        man_sel_d = 2'd0;
        state_d   = S_RD_SEL;
      end
      S_RD_SEL: begin
        wait_d  = RL_W'(READ_LAT - 1);
        state_d = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (wait_q != '0) begin
          wait_d = wait_q - RL_W'(1);
        end else begin
          case (idx_q)
            2'd0:    r_d = cur_coef_i;
            2'd1:    g_d = cur_coef_i;
            default: b_d = cur_coef_i;
          endcase
          if (idx_q == 2'd2) begin
            // first write cycle (R) is set up here so WR emits one channel per cycle
            idx_d      = 2'd0;
            man_sel_d  = 2'd0;
            man_coef_d = r_q;
            man_lock_d = 1'b1;
            state_d    = S_WR;
          end else begin
            idx_d     = idx_nxt;
            man_sel_d = idx_nxt;
            state_d   = S_RD_SEL;
          end
        end
      end
      S_WR: begin
        if (idx_q == 2'd2) begin
          idx_d   = 2'd0;
          mode_d  = MODE_MANUAL;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_SWITCH;
        end else begin
          idx_d      = idx_nxt;
          man_sel_d  = idx_nxt;
          man_coef_d = (idx_nxt == 2'd1) ? g_q : b_q;
          man_lock_d = 1'b1;
        end
      end
      S_SWITCH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    // abort wins over everything else; captured coefficients and err are left untouched
    if (abort_i && (state_q != S_IDLE)) begin
      state_d    = S_IDLE;
      mode_d     = MODE_AUTO_GW;
      cal_stb_d  = 1'b0;
      man_lock_d = 1'b0;
      busy_d     = 1'b0;
      done_d     = 1'b0;
      err_d      = err_q;
      r_d        = r_q;
      g_d        = g_q;
      b_d        = b_q;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= S_IDLE;
      frame_cnt_q <= '0;
      wd_q        <= '0;
      wait_q      <= '0;
      idx_q       <= 2'd0;
      mode_q      <= MODE_AUTO_GW;
      cal_stb_q   <= 1'b0;
      man_sel_q   <= 2'd0;
      man_lock_q  <= 1'b0;
      man_coef_q  <= '0;
      r_q         <= COEF_ONE;
      g_q         <= COEF_ONE;
      b_q         <= COEF_ONE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      frame_cnt_q <= frame_cnt_d;
      wd_q        <= wd_d;
      wait_q      <= wait_d;
      idx_q       <= idx_d;
      mode_q      <= mode_d;
      cal_stb_q   <= cal_stb_d;
      man_sel_q   <= man_sel_d;
      man_lock_q  <= man_lock_d;
      man_coef_q  <= man_coef_d;
      r_q         <= r_d;
      g_q         <= g_d;
      b_q         <= b_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign mode_o     = mode_q;
  assign cal_stb_o  = cal_stb_q;
  assign man_sel_o  = man_sel_q;
  assign man_lock_o = man_lock_q;
  assign man_coef_o = man_coef_q;
  assign r_coef_o   = r_q;
  assign g_coef_o   = g_q;
  assign b_coef_o   = b_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_wb_cal_sequencer.sv
// Directed bench for wb_cal_sequencer with a READ_LAT-deep model of the corrector's coefficient readback.
// Runs with TIMEOUT_CYCLES=1000 so the watchdog path is reachable quickly.
module tb_wb_cal_sequencer;

  localparam int CW = 20;

  logic          clk = 1'b0;
  logic          rstn_i = 1'b0;
  logic          start_i = 1'b0;
  logic          abort_i = 1'b0;
  logic [7:0]    settle_frames_i = 8'd0;
  logic          sof_i = 1'b0;
  logic [CW-1:0] cur_coef_i;
  logic [1:0]    mode_o;
  logic          cal_stb_o;
  logic [1:0]    man_sel_o;
  logic          man_lock_o;
  logic [CW-1:0] man_coef_o;
  logic [CW-1:0] r_coef_o, g_coef_o, b_coef_o;
  logic          busy_o, done_o, err_o;

  int n_cmp = 0;
  int n_err = 0;

  wb_cal_sequencer #(
    .COEF_WIDTH(CW), .FRAME_CNT_WIDTH(8), .READ_LAT(2), .TIMEOUT_CYCLES(1000)
  ) dut (
    .clk_i(clk), .rstn_i(rstn_i), .start_i(start_i), .abort_i(abort_i),
    .settle_frames_i(settle_frames_i), .sof_i(sof_i), .cur_coef_i(cur_coef_i),
    .mode_o(mode_o), .cal_stb_o(cal_stb_o), .man_sel_o(man_sel_o),
    .man_lock_o(man_lock_o), .man_coef_o(man_coef_o),
    .r_coef_o(r_coef_o), .g_coef_o(g_coef_o), .b_coef_o(b_coef_o),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  // corrector model: coefficient for man_sel_o appears two cycles after the select changes
  logic [CW-1:0] mdl [0:2];
  logic [CW-1:0] st1, st2;
  always @(posedge clk) begin
    st1 <= (man_sel_o == 2'd3) ? '0 : mdl[man_sel_o];
    st2 <= st1;
  end
  assign cur_coef_i = st2;

  // event monitor sampled on the falling edge
  int            cal_cnt = 0, lock_cnt = 0, done_cnt = 0, overlap_cnt = 0;
  logic [1:0]    lock_sel  [0:63];
  logic [CW-1:0] lock_coef [0:63];
  always @(negedge clk) begin
    if (rstn_i) begin
      if (cal_stb_o) cal_cnt <= cal_cnt + 1;
      if (done_o) done_cnt <= done_cnt + 1;
      if (cal_stb_o && man_lock_o) overlap_cnt <= overlap_cnt + 1;
      if (man_lock_o) begin
        lock_sel[lock_cnt[5:0]]  <= man_sel_o;
        lock_coef[lock_cnt[5:0]] <= man_coef_o;
        lock_cnt <= lock_cnt + 1;
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [7:0] n, input logic with_sof);
    settle_frames_i = n;
    start_i = 1'b1;
    sof_i = with_sof;
    tick();
    start_i = 1'b0;
    sof_i = 1'b0;
  endtask

  task automatic pulse_sof;
    sof_i = 1'b1;
    tick();
    sof_i = 1'b0;
  endtask

  // returns number of ticks until done_o is seen; equals bound on expiry
  task automatic wait_done(input int bound, output int n);
    n = 0;
    while (done_o !== 1'b1 && n < bound) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset;
    rstn_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (mode_o !== 2'd0) begin n_err++; $display("FAIL reset_mode: got %0d want 0", mode_o); end
    n_cmp++; if (cal_stb_o !== 1'b0) begin n_err++; $display("FAIL reset_cal_stb: got %b want 0", cal_stb_o); end
    n_cmp++; if (man_lock_o !== 1'b0) begin n_err++; $display("FAIL reset_man_lock: got %b want 0", man_lock_o); end
    n_cmp++; if (man_sel_o !== 2'd0) begin n_err++; $display("FAIL reset_man_sel: got %0d want 0", man_sel_o); end
    n_cmp++; if (man_coef_o !== 20'h0) begin n_err++; $display("FAIL reset_man_coef: got %h want 00000", man_coef_o); end
    n_cmp++; if (r_coef_o !== 20'h00400) begin n_err++; $display("FAIL reset_r_coef: got %h want 00400", r_coef_o); end
    n_cmp++; if (g_coef_o !== 20'h00400) begin n_err++; $display("FAIL reset_g_coef: got %h want 00400", g_coef_o); end
    n_cmp++; if (b_coef_o !== 20'h00400) begin n_err++; $display("FAIL reset_b_coef: got %h want 00400", b_coef_o); end
    n_cmp++; if ({busy_o, done_o, err_o} !== 3'b000) begin n_err++; $display("FAIL reset_flags: busy/done/err got %b want 000", {busy_o, done_o, err_o}); end
    @(negedge clk);
    rstn_i = 1'b1;
    tick();
  endtask

  task automatic test_basic;
    int cb, lb, db, n;
    mdl[0] = 20'h00477; mdl[1] = 20'h00400; mdl[2] = 20'h00527;
    cb = cal_cnt; lb = lock_cnt; db = done_cnt;
    pulse_start(8'd2, 1'b0);
    n_cmp++; if (mode_o !== 2'd3 || busy_o !== 1'b1) begin n_err++; $display("FAIL basic_enter_cal: mode/busy got %0d/%b want 3/1", mode_o, busy_o); end
    repeat (99) tick();
    pulse_sof();
    repeat (99) tick();
    n_cmp++; if (cal_cnt - cb !== 0) begin n_err++; $display("FAIL basic_no_early_stb: got %0d strobes want 0", cal_cnt - cb); end
    pulse_sof();
    wait_done(100, n);
    n_cmp++; if (n !== 15) begin n_err++; $display("FAIL basic_done_latency: got %0d ticks after 2nd sof want 15", n); end
    n_cmp++; if (mode_o !== 2'd2 || busy_o !== 1'b0) begin n_err++; $display("FAIL basic_switch: mode/busy got %0d/%b want 2/0", mode_o, busy_o); end
    n_cmp++; if (cal_cnt - cb !== 1) begin n_err++; $display("FAIL basic_stb_count: got %0d want 1", cal_cnt - cb); end
    n_cmp++; if ({r_coef_o, g_coef_o, b_coef_o} !== {20'h00477, 20'h00400, 20'h00527}) begin n_err++; $display("FAIL basic_capture: got %h/%h/%h want 00477/00400/00527", r_coef_o, g_coef_o, b_coef_o); end
    n_cmp++; if (lock_cnt - lb !== 3) begin n_err++; $display("FAIL basic_lock_count: got %0d want 3", lock_cnt - lb); end
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (lock_sel[(lb + i) % 64] !== i[1:0] || lock_coef[(lb + i) % 64] !== mdl[i]) begin
        n_err++; $display("FAIL basic_write_%0d: sel/coef got %0d/%h want %0d/%h", i, lock_sel[(lb + i) % 64], lock_coef[(lb + i) % 64], i, mdl[i]);
      end
    end
    tick();
    n_cmp++; if (done_o !== 1'b0 || mode_o !== 2'd2) begin n_err++; $display("FAIL basic_after_done: done/mode got %b/%0d want 0/2", done_o, mode_o); end
    repeat (3) tick();
    n_cmp++; if (done_cnt - db !== 1 || overlap_cnt !== 0) begin n_err++; $display("FAIL basic_done_pulse: dones/overlaps got %0d/%0d want 1/0", done_cnt - db, overlap_cnt); end
  endtask

  task automatic test_zero_settle;
    int lb, n;
    mdl[0] = 20'h12345; mdl[1] = 20'hABCDE; mdl[2] = 20'h55555;
    lb = lock_cnt;
    pulse_start(8'd0, 1'b0);
    n_cmp++; if (mode_o !== 2'd3 || cal_stb_o !== 1'b0) begin n_err++; $display("FAIL zero_enter: mode/stb got %0d/%b want 3/0", mode_o, cal_stb_o); end
    tick();
    n_cmp++; if (cal_stb_o !== 1'b1) begin n_err++; $display("FAIL zero_stb_high: got %b want 1", cal_stb_o); end
    tick();
    n_cmp++; if (cal_stb_o !== 1'b0) begin n_err++; $display("FAIL zero_stb_single: got %b want 0", cal_stb_o); end
    wait_done(100, n);
    // start cycle + 15 edges = 16-cycle latency
    n_cmp++; if (n + 2 !== 15) begin n_err++; $display("FAIL zero_done_latency: got %0d ticks want 15", n + 2); end
    n_cmp++; if ({r_coef_o, g_coef_o, b_coef_o} !== {20'h12345, 20'hABCDE, 20'h55555}) begin n_err++; $display("FAIL zero_capture: got %h/%h/%h want 12345/abcde/55555", r_coef_o, g_coef_o, b_coef_o); end
    n_cmp++;
    if (lock_cnt - lb !== 3 || lock_coef[(lb + 1) % 64] !== 20'hABCDE || lock_sel[(lb + 2) % 64] !== 2'd2) begin
      n_err++; $display("FAIL zero_writes: count %0d G %h sel2 %0d want 3 abcde 2", lock_cnt - lb, lock_coef[(lb + 1) % 64], lock_sel[(lb + 2) % 64]);
    end
    tick();
  endtask

  task automatic test_timeout;
    int cb, db, n;
    cb = cal_cnt; db = done_cnt;
    pulse_start(8'd3, 1'b0);
    repeat (999) tick();
    n_cmp++; if (err_o !== 1'b0 || mode_o !== 2'd3) begin n_err++; $display("FAIL timeout_early: err/mode got %b/%0d want 0/3", err_o, mode_o); end
    tick();
    n_cmp++; if (err_o !== 1'b1 || mode_o !== 2'd0 || busy_o !== 1'b0) begin n_err++; $display("FAIL timeout_fire: err/mode/busy got %b/%0d/%b want 1/0/0", err_o, mode_o, busy_o); end
    repeat (5) tick();
    n_cmp++; if (cal_cnt - cb !== 0 || done_cnt - db !== 0 || err_o !== 1'b1) begin n_err++; $display("FAIL timeout_quiet: stb/done/err got %0d/%0d/%b want 0/0/1", cal_cnt - cb, done_cnt - db, err_o); end
    pulse_start(8'd0, 1'b0);
    n_cmp++; if (err_o !== 1'b0) begin n_err++; $display("FAIL timeout_err_clear: got %b want 0", err_o); end
    wait_done(100, n);
    n_cmp++; if (done_o !== 1'b1) begin n_err++; $display("FAIL timeout_rerun_done: got %b want 1", done_o); end
    tick();
  endtask

  task automatic test_abort;
    int lb, db, cb;
    mdl[0] = 20'h11111; mdl[1] = 20'h22222; mdl[2] = 20'h33333;
    lb = lock_cnt; db = done_cnt; cb = cal_cnt;
    pulse_start(8'd0, 1'b0);
    repeat (7) tick();
    n_cmp++; if (man_sel_o !== 2'd1 || r_coef_o !== 20'h11111) begin n_err++; $display("FAIL abort_in_rd_g: sel/r got %0d/%h want 1/11111", man_sel_o, r_coef_o); end
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    n_cmp++; if (mode_o !== 2'd0 || busy_o !== 1'b0) begin n_err++; $display("FAIL abort_idle: mode/busy got %0d/%b want 0/0", mode_o, busy_o); end
    repeat (30) tick();
    n_cmp++; if (r_coef_o !== 20'h11111 || g_coef_o !== 20'hABCDE) begin n_err++; $display("FAIL abort_keep_coef: r/g got %h/%h want 11111/abcde", r_coef_o, g_coef_o); end
    n_cmp++; if (lock_cnt - lb !== 0 || done_cnt - db !== 0 || cal_cnt - cb !== 1) begin n_err++; $display("FAIL abort_events: lock/done/stb got %0d/%0d/%0d want 0/0/1", lock_cnt - lb, done_cnt - db, cal_cnt - cb); end
    n_cmp++; if (mode_o !== 2'd0 || err_o !== 1'b0) begin n_err++; $display("FAIL abort_stays: mode/err got %0d/%b want 0/0", mode_o, err_o); end
  endtask

  task automatic test_start_busy;
    int db, n;
    db = done_cnt;
    pulse_start(8'd2, 1'b1);
    repeat (49) tick();
    pulse_sof();
    repeat (29) tick();
    pulse_start(8'd5, 1'b0);
    n_cmp++; if (mode_o !== 2'd3 || busy_o !== 1'b1) begin n_err++; $display("FAIL busy_start_ignored: mode/busy got %0d/%b want 3/1", mode_o, busy_o); end
    repeat (19) tick();
    n_cmp++; if (done_cnt - db !== 0 || busy_o !== 1'b1) begin n_err++; $display("FAIL busy_still_settling: done/busy got %0d/%b want 0/1", done_cnt - db, busy_o); end
    pulse_sof();
    wait_done(100, n);
    n_cmp++; if (n !== 15) begin n_err++; $display("FAIL busy_done_latency: got %0d ticks want 15", n); end
    repeat (3) tick();
    n_cmp++; if (done_cnt - db !== 1) begin n_err++; $display("FAIL busy_single_done: got %0d want 1", done_cnt - db); end
  endtask

  task automatic test_async_reset;
    pulse_start(8'd0, 1'b0);
    repeat (12) tick();
    n_cmp++; if (man_lock_o !== 1'b1 || man_sel_o !== 2'd0 || man_coef_o !== 20'h11111) begin n_err++; $display("FAIL rst_wr_r: lock/sel/coef got %b/%0d/%h want 1/0/11111", man_lock_o, man_sel_o, man_coef_o); end
    tick();
    n_cmp++; if (man_lock_o !== 1'b1 || man_sel_o !== 2'd1 || man_coef_o !== 20'h22222) begin n_err++; $display("FAIL rst_wr_g: lock/sel/coef got %b/%0d/%h want 1/1/22222", man_lock_o, man_sel_o, man_coef_o); end
    #2 rstn_i = 1'b0;
    #1;
    n_cmp++; if (man_lock_o !== 1'b0) begin n_err++; $display("FAIL rst_lock_drop: got %b want 0", man_lock_o); end
    n_cmp++; if (mode_o !== 2'd0 || man_sel_o !== 2'd0 || man_coef_o !== 20'h0 || cal_stb_o !== 1'b0) begin n_err++; $display("FAIL rst_ctrl: mode/sel/coef/stb got %0d/%0d/%h/%b want 0/0/00000/0", mode_o, man_sel_o, man_coef_o, cal_stb_o); end
    n_cmp++; if ({r_coef_o, g_coef_o, b_coef_o} !== {3{20'h00400}}) begin n_err++; $display("FAIL rst_coefs: got %h/%h/%h want 00400 each", r_coef_o, g_coef_o, b_coef_o); end
    n_cmp++; if ({busy_o, done_o, err_o} !== 3'b000) begin n_err++; $display("FAIL rst_flags: busy/done/err got %b want 000", {busy_o, done_o, err_o}); end
    @(negedge clk);
    rstn_i = 1'b1;
    repeat (3) tick();
    n_cmp++; if (mode_o !== 2'd0 || busy_o !== 1'b0 || man_lock_o !== 1'b0) begin n_err++; $display("FAIL rst_release_idle: mode/busy/lock got %0d/%b/%b want 0/0/0", mode_o, busy_o, man_lock_o); end
  endtask

  initial begin
    mdl[0] = '0; mdl[1] = '0; mdl[2] = '0;
    test_reset();
    test_basic();
    test_zero_settle();
    test_timeout();
    test_abort();
    test_start_busy();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/wb_cal_sequencer.md
Name: wb_cal_sequencer

Overview:
- Controller for the white balance corrector's control interface.
- On a start command it:
  - puts the corrector in calibration mode;
  - lets the gray-world estimator settle for a programmable number of frames;
  - strobes the calibration latch;
  - reads back the latched R/G/B coefficients;
  - writes them into the manual coefficient registers;
  - switches the corrector to manual mode, freezing the balance.
- Sits between the CSR block and the corrector's control port.

Parameters:
- COEF_WIDTH, 20, coefficient width (PX_WIDTH + FRACT_WIDTH), unsigned fixed point.
- FRAME_CNT_WIDTH, 8, width of the settle-frame count.
- READ_LAT, 2, cycles from man_sel change to valid cur_coef.
- TIMEOUT_CYCLES, 2**24, maximum cycles allowed between frame starts while settling.

Ports:
- clk_i  in  1  clock.
- rstn_i  in  1  asynchronous active-low reset.
- start_i  in  1  single-cycle start pulse; ignored unless IDLE.
- abort_i  in  1  single-cycle abort pulse.
- settle_frames_i  in  FRAME_CNT_WIDTH  frames to wait before strobe; sampled on accepted start.
- sof_i  in  1  frame start: video tvalid && tready && tuser.
- cur_coef_i  in  COEF_WIDTH  corrector current coefficient for man_sel_o.
- mode_o  out  2  corrector mode: 0 AUTO_GW, 1 AUTO_R, 2 MANUAL, 3 CALIBRATION.
- cal_stb_o  out  1  calibration latch strobe.
- man_sel_o  out  2  channel select: 0 R, 1 G, 2 B.
- man_lock_o  out  1  manual coefficient write enable.
- man_coef_o  out  COEF_WIDTH  manual coefficient write data.
- r_coef_o, g_coef_o, b_coef_o  out  COEF_WIDTH each  captured coefficients.
- busy_o  out  1  sequence in progress.
- done_o  out  1  single-cycle pulse on successful completion.
- err_o  out  1  sticky timeout flag; cleared by next accepted start.

Behaviour:
- Reset values:
  - mode_o=0 (AUTO_GW).
  - cal_stb_o, man_lock_o, busy_o, done_o, err_o = 0.
  - man_sel_o=0, man_coef_o=0.
  - r/g/b_coef_o = 1.0, i.e. 1 << (COEF_WIDTH/2).
- All outputs are registered.
- States: IDLE, SETTLE, STROBE, LATCH, RD_SEL, RD_WAIT, WR, SWITCH.
- IDLE:
  - busy_o=0.
  - On start_i: latch settle_frames_i into frame counter, clear err_o, set mode_o=3, set busy_o=1, go to SETTLE.
- SETTLE:
  - Each sof_i decrements the frame counter.
  - When the counter is 0 (including settle_frames_i=0), go to STROBE.
  - A watchdog counts cycles since the last sof_i or state entry.
  - Watchdog reaching TIMEOUT_CYCLES: set err_o=1, mode_o=0, go to IDLE; no done_o.
- STROBE: cal_stb_o=1 for exactly one cycle, then LATCH.
- LATCH: one idle cycle so the corrector's coefficient registers update, then RD_SEL with channel index=0.
- RD_SEL: drive man_sel_o=index, go to RD_WAIT.
- RD_WAIT:
  - Wait READ_LAT cycles after man_sel_o change.
  - Then capture cur_coef_i into r/g/b_coef_o for index 0/1/2.
  - Index<2: increment, go to RD_SEL. Else: index=0, go to WR.
- WR:
  - Per channel, one cycle with man_sel_o=index, man_coef_o=captured value, man_lock_o=1.
  - Three consecutive write cycles R, G, B, then SWITCH.
- SWITCH:
  - mode_o=2, done_o=1 for one cycle, busy_o=0, go to IDLE.
  - mode_o stays 2 until the next start.
- Abort:
  - abort_i in any non-IDLE state: go to IDLE next cycle, mode_o=0, cal_stb_o=0, man_lock_o=0.
  - Captured coefficients are kept; no done_o; err_o unchanged.
- Simultaneous events:
  - abort_i has priority over sof_i, the timeout and start_i.
  - start_i while busy is ignored.
  - sof_i in the same cycle as start_i is not counted.
- Single-cycle outputs: cal_stb_o and man_lock_o are never high in the same cycle; each is high only in its state.
- Latency, settle_frames=N, no stalls: 1 + (N frames) + 1 + 1 + 3*(1+READ_LAT) + 3 + 1 cycles.
- Reset mid-sequence returns to reset values immediately (asynchronous).

Test Plan:
- Basic sequence: settle_frames=2, start, sof every 100 cycles, cur_coef model returning R=0x00477, G=0x00400, B=0x00527 -> mode 3 then 2; one cal_stb after 2nd sof; captured values match; three man_lock writes R,G,B with those values; one done pulse.
- Zero settle: settle_frames=0 -> cal_stb 1 cycle after mode=3 with no sof needed; done after the fixed latency of 16 cycles.
- Timeout: TIMEOUT_CYCLES=1000, no sof -> err_o=1 at cycle 1000, mode_o=0, no cal_stb, no done; next start clears err_o.
- Abort: abort during RD_WAIT of G -> IDLE next cycle, mode_o=0, no man_lock ever asserted, r_coef_o holds the read R value.
- Start while busy: second start pulse mid-SETTLE -> ignored, frame count unchanged, single done.
- Async reset: assert rstn_i=0 during WR -> man_lock_o drops immediately, all outputs at reset values.
